// File: rtl/serial_comparator_dual_order_fsm.sv
// serial_comparator_dual_order_fsm: bit-serial unsigned compare, LSB-first and MSB-first Mealy FSMs
module serial_comparator_dual_order_fsm (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic lsb_less,
  output logic lsb_eq,
  output logic lsb_greater,
  output logic msb_less,
  output logic msb_eq,
  output logic msb_greater
);
  typedef enum logic [1:0] {EQ, LT, GT} state_t;
  state_t lsb_q, lsb_d, msb_q, msb_d;
  logic gt_bit, lt_bit;
  always_ff @(posedge clk)
    if (!rst) begin
      lsb_q <= EQ;
      msb_q <= EQ;
    end else begin
      lsb_q <= lsb_d;
      msb_q <= msb_d;
    end
  // The Mealy verdict including the current bit is exactly the state that bit leads to.
  always_comb begin
    gt_bit = a & ~b;
    lt_bit = ~a & b;
    lsb_d = gt_bit ? GT : lt_bit ? LT : lsb_q;
    msb_d = (msb_q != EQ) ? msb_q : gt_bit ? GT : lt_bit ? LT : EQ;
    lsb_less = lsb_d == LT;
    lsb_eq = lsb_d == EQ;
    lsb_greater = lsb_d == GT;
    msb_less = msb_d == LT;
    msb_eq = msb_d == EQ;
    msb_greater = msb_d == GT;
  end
endmodule

// File: tb/tb_serial_comparator_dual_order_fsm.sv
// tb_serial_comparator_dual_order_fsm: random and directed streams checked against an integer-compare model
module tb_serial_comparator_dual_order_fsm;
  logic clk = 0, rst = 0, a = 0, b = 0;
  logic lsb_less, lsb_eq, lsb_greater, msb_less, msb_eq, msb_greater;
  int vecs = 0, errs = 0;
  logic [127:0] la, lb, ma, mb;
  int n = 0;
  bit started = 0;
  serial_comparator_dual_order_fsm dut (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .lsb_less(lsb_less), .lsb_eq(lsb_eq), .lsb_greater(lsb_greater),
    .msb_less(msb_less), .msb_eq(msb_eq), .msb_greater(msb_greater)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s t=%0t got %b want %b (less,eq,greater)", nm, $time, got, exp);
    end
  endtask
  function automatic logic [2:0] verdict(input logic [127:0] x, input logic [127:0] y);
    return {x < y, x == y, x > y};
  endfunction
  // History of bits since the last reset edge, as LSB-first and MSB-first integers.
  always @(posedge clk)
    if (!rst) begin
      started <= 1;
      n <= 0;
      la <= '0; lb <= '0; ma <= '0; mb <= '0;
    end else if (started && n < 127) begin
      la[n] <= a;
      lb[n] <= b;
      ma <= {ma[126:0], a};
      mb <= {mb[126:0], b};
      n <= n + 1;
    end
  always @(negedge clk)
    if (started) begin
      logic [127:0] ca, cb;
      ca = la; cb = lb;
      ca[n] = a; cb[n] = b;
      chk("lsb_model", {lsb_less, lsb_eq, lsb_greater}, verdict(ca, cb));
      chk("msb_model", {msb_less, msb_eq, msb_greater}, verdict({ma[126:0], a}, {mb[126:0], b}));
      chk("lsb_onehot", {2'b0, $onehot({lsb_less, lsb_eq, lsb_greater})}, 3'b001);
      chk("msb_onehot", {2'b0, $onehot({msb_less, msb_eq, msb_greater})}, 3'b001);
    end
  task automatic step(input logic aa, input logic bb, input logic rr);
    @(posedge clk);
    #1;
    a = aa; b = bb; rst = rr;
    #2;
  endtask
  task automatic run_case(input string nm, input logic [15:0] wa, input logic [15:0] wb,
                          input logic [15:0] ll, input logic [15:0] le, input logic [15:0] lg,
                          input logic [15:0] ml, input logic [15:0] me, input logic [15:0] mg);
    step(0, 0, 0);
    for (int j = 0; j < 16; j++) begin
      step(wa[j], wb[j], 1);
      chk({nm, "_lsb"}, {lsb_less, lsb_eq, lsb_greater}, {ll[j], le[j], lg[j]});
      chk({nm, "_msb"}, {msb_less, msb_eq, msb_greater}, {ml[j], me[j], mg[j]});
    end
  endtask
  initial begin
    step(0, 0, 0);
    chk("reset_lsb", {lsb_less, lsb_eq, lsb_greater}, 3'b010);
    chk("reset_msb", {msb_less, msb_eq, msb_greater}, 3'b010);
    run_case("case1", 16'b0100_0001_0010_0110, 16'b0100_0110_0100_0110,
             16'b1111_1110_1100_0000, 16'b0000_0000_0001_1111, 16'b0000_0001_0010_0000,
             16'h0000, 16'b0000_0000_0001_1111, 16'b1111_1111_1110_0000);
    run_case("case2", 16'b0100_0001_0000_0110, 16'b0101_0110_0100_0110,
             16'b1111_1110_1100_0000, 16'b0000_0000_0011_1111, 16'b0000_0001_0000_0000,
             16'b1111_1111_1100_0000, 16'b0000_0000_0011_1111, 16'h0000);
    run_case("equal", 16'b0100_0111_0010_0110, 16'b0100_0111_0010_0110,
             16'h0000, 16'hffff, 16'h0000, 16'h0000, 16'hffff, 16'h0000);
    step(0, 0, 0);
    repeat (3) step(1, 0, 1);
    step(1, 0, 0);
    step(0, 0, 1);
    chk("midrst_eq_lsb", {lsb_less, lsb_eq, lsb_greater}, 3'b010);
    chk("midrst_eq_msb", {msb_less, msb_eq, msb_greater}, 3'b010);
    step(0, 1, 1);
    chk("midrst_lt_lsb", {lsb_less, lsb_eq, lsb_greater}, 3'b100);
    chk("midrst_lt_msb", {msb_less, msb_eq, msb_greater}, 3'b100);
    step(0, 0, 0);
    step(1, 0, 1);
    chk("ovr0_lsb", {lsb_less, lsb_eq, lsb_greater}, 3'b001);
    chk("ovr0_msb", {msb_less, msb_eq, msb_greater}, 3'b001);
    step(0, 1, 1);
    chk("ovr1_lsb", {lsb_less, lsb_eq, lsb_greater}, 3'b100);
    chk("ovr1_msb", {msb_less, msb_eq, msb_greater}, 3'b001);
    step(0, 0, 1);
    chk("ovr2_lsb", {lsb_less, lsb_eq, lsb_greater}, 3'b100);
    chk("ovr2_msb", {msb_less, msb_eq, msb_greater}, 3'b001);
    for (int s = 0; s < 40; s++) begin
      step(0, 0, 0);
      for (int j = 0; j < 64; j++)
        step(1'($urandom), 1'($urandom), $urandom_range(31) != 0);
    end
    step(0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/serial_comparator_dual_order_fsm.md
Name: serial_comparator_dual_order_fsm

Overview:
- Compares two unsigned numbers `a` and `b` that arrive serially, one bit pair per clock.
- Contains two independent 3-state comparator FSMs sharing the same inputs:
  - LSB-first: bits arrive least significant first.
  - MSB-first: bits arrive most significant first.
- Each FSM gives a one-hot less/eq/greater verdict covering all bits received since reset, including the bit currently on the inputs.
- Used as a serial-stream comparison primitive and as a reference pair for cross-checking bit ordering.

Parameters:
- none (bit-serial; the operand length is unbounded and set only by the time between resets)

Ports:
- `clk`  input  1  clock; all state updates on the rising edge
- `rst`  input  1  synchronous reset, active-low (0 = reset asserted)
- `a`  input  1  current serial bit of operand A
- `b`  input  1  current serial bit of operand B
- `lsb_less`  output  1  LSB-first verdict: A < B
- `lsb_eq`  output  1  LSB-first verdict: A == B
- `lsb_greater`  output  1  LSB-first verdict: A > B
- `msb_less`  output  1  MSB-first verdict: A < B
- `msb_eq`  output  1  MSB-first verdict: A == B
- `msb_greater`  output  1  MSB-first verdict: A > B

Behaviour:
- Each FSM has three states: EQ, LT, GT.
- Reset:
  - When `rst` = 0 at a rising edge, both FSMs go to EQ, regardless of `a`/`b`.
  - Asserting reset mid-stream discards all history; the next bit is treated as the first bit.
- Outputs are Mealy: purely combinational from the current state and the current `a`/`b`, with no register on the outputs.
  - The verdict for bit j is valid in the same cycle bit j is presented, before the edge that absorbs it. Latency is 0.
- Each output triple is always exactly one-hot.
- Per-bit decision, shared by both FSMs: `a`=1,`b`=0 → "greater"; `a`=0,`b`=1 → "less"; `a`==`b` → "no decision".
- LSB-first FSM (later bits are more significant, so they override):
  - Output: if the bits differ, output the per-bit decision; otherwise output the state (EQ→eq, LT→less, GT→greater).
  - Next state, any state: differing bits → GT or LT per the decision; equal bits → hold the state.
  - LT↔GT transitions are allowed at any time.
- MSB-first FSM (the first differing bit decides permanently):
  - In EQ: the output equals the per-bit decision (eq if the bits are equal). Next state: GT or LT if the bits differ, else stay in EQ.
  - LT and GT are absorbing until reset. Their outputs are less or greater regardless of the inputs.
- While `rst` = 0, the outputs are still computed combinationally from the current state and inputs; they are not forced.
- There is no frame-length counter. The comparison covers all bits since the last reset.
- Inputs are sampled only at the rising edge; `a`/`b` must be stable around the edge.

Test Plan (bits listed bit0 first = first cycle after reset release; vectors are written MSB...LSB of a 16-bit word, and word bit j is sent in cycle j):
- Case 1, A=0100_0001_0010_0110, B=0100_0110_0100_0110:
  - LSB outputs, less/eq/greater = 1111_1110_1100_0000 / 0000_0000_0001_1111 / 0000_0001_0010_0000.
  - MSB outputs = 0 / 0000_0000_0001_1111 / 1111_1111_1110_0000.
- Case 2, A=0100_0001_0000_0110, B=0101_0110_0100_0110:
  - LSB less/eq/greater = 1111_1110_1100_0000 / 0000_0000_0011_1111 / 0000_0001_0000_0000.
  - MSB = 1111_1111_1100_0000 / 0000_0000_0011_1111 / 0.
- Equal case, A=B=0100_0111_0010_0110: both `eq` outputs are 1 every cycle; all `less`/`greater` outputs are 0 for all 16 cycles.
- Reset mid-stream: drive `a`=1,`b`=0 for 3 cycles, pull `rst` low for 1 edge, then drive `a`=0,`b`=0.
  - Both `eq` = 1 on the first post-reset cycle.
  - Then drive `a`=0,`b`=1: both `less` = 1.
- LSB override and MSB lock: sequence (1,0),(0,1),(0,0).
  - LSB: greater, less, less.
  - MSB: greater, greater, greater.
- One-hot check: random 64-bit streams with random resets.
  - Each output triple is exactly one-hot every cycle.
  - After the last bit, LSB and MSB verdicts match an integer compare of A vs B assembled in the respective bit order.
